gshare_predictor_2bc: RTL and testbench

//  Parametrised gshare branch predictor with an internal table of 2-bit saturating counters.
//  The table index is the branch address XOR the global history register (GHR).

---
 rtl/gshare_predictor_2bc.sv | 64 ++++++
 tb/tb_gshare_predictor_2bc.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor_2bc.sv
// gshare_predictor_2bc: gshare branch predictor over a self-initialising table of 2-bit saturating counters.
module gshare_predictor_2bc #(
  parameter int ADDR_W = 8,
  parameter int HIST_W = 8,
  parameter logic [1:0] CTR_INIT = 2'b01,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [ADDR_W-1:0] pred_adrs,
  output logic              pred_rdy,
  output logic              prdbit,
  output logic              prdbit_vld,
  output logic [ADDR_W-1:0] pred_idx,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [HIST_W-1:0] ghr,
  output logic [CNT_W-1:0]  mispred_cnt
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr, idx, wr_idx;
  logic [1:0] tbl [2**ADDR_W];
  logic [1:0] cur, wr_data;
  logic wr_en, pred_go, upd_go;
  always_ff @(posedge clk)
    if (rst) state <= INIT;
    else state <= state_nxt;
  always_comb state_nxt = (state == INIT && &ptr) ? RUN : state;
  assign pred_rdy = state == RUN;
  assign pred_go  = pred_valid & pred_rdy;
  assign upd_go   = upd_valid & pred_rdy;
  assign idx      = pred_adrs ^ ADDR_W'(ghr);
  assign cur      = tbl[upd_idx];
  // the single write port is shared between the init sweep and resolved updates
  assign wr_en    = !rst & (!pred_rdy | upd_go);
  assign wr_idx   = pred_rdy ? upd_idx : ptr;
  assign wr_data  = !pred_rdy ? CTR_INIT :
                    upd_taken ? (&cur ? cur : cur + 2'd1) : (|cur ? cur - 2'd1 : cur);
  always_ff @(posedge clk)
    if (wr_en) tbl[wr_idx] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      ghr         <= '0;
      prdbit      <= 1'b0;
      prdbit_vld  <= 1'b0;
      pred_idx    <= '0;
      mispred_cnt <= '0;
    end else begin
      if (state == INIT) ptr <= ptr + ADDR_W'(1);
      prdbit_vld <= pred_go;
      if (pred_go) begin
        prdbit   <= tbl[idx][1];
        pred_idx <= idx;
      end
      if (upd_go) ghr <= (ghr << 1) | HIST_W'(upd_taken);
      if (upd_go && upd_taken != upd_pred && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_gshare_predictor_2bc.sv
// tb_gshare_predictor_2bc: scoreboard bench with a reference model of table, history and counters.
module tb_gshare_predictor_2bc;
  logic clk = 0, rst = 1;
  logic pred_valid = 0, upd_valid = 0, upd_taken = 0, upd_pred = 0;
  logic [7:0] pred_adrs = 0, upd_idx = 0, pred_idx, ghr;
  logic pred_rdy, prdbit, prdbit_vld;
  logic [15:0] mispred_cnt;
  logic upd_valid2 = 0;
  logic pred_rdy2, prdbit2, prdbit_vld2;
  logic [3:0] pred_idx2, mispred_cnt2;
  logic [1:0] ghr2;
  int total = 0, bad = 0;
  logic [1:0] mtbl [256];
  logic [7:0] mghr, m_idx;
  logic [15:0] mcnt;
  logic [3:0] mcnt2;
  logic m_bit;
  int init_left, init2_left;
  bit started = 0;
  logic [8:0] q [$];

  always #5 clk = ~clk;

  gshare_predictor_2bc dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_adrs(pred_adrs), .pred_rdy(pred_rdy),
    .prdbit(prdbit), .prdbit_vld(prdbit_vld), .pred_idx(pred_idx), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_pred(upd_pred), .ghr(ghr), .mispred_cnt(mispred_cnt)
  );

  gshare_predictor_2bc #(.ADDR_W(4), .HIST_W(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .pred_valid(1'b0), .pred_adrs(4'h0), .pred_rdy(pred_rdy2),
    .prdbit(prdbit2), .prdbit_vld(prdbit_vld2), .pred_idx(pred_idx2), .upd_valid(upd_valid2),
    .upd_idx(4'h3), .upd_taken(1'b1), .upd_pred(1'b0), .ghr(ghr2), .mispred_cnt(mispred_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e_idx;
    @(posedge clk);
    if (rst) begin
      init_left = 256; init2_left = 16;
      mghr = 0; mcnt = 0; mcnt2 = 0; m_bit = 0; m_idx = 0;
      foreach (mtbl[i]) mtbl[i] = 2'b01;
      q.delete();
    end else begin
      if (init2_left > 0) init2_left--;
      else if (upd_valid2 && mcnt2 != 4'hF) mcnt2++;
      if (init_left > 0) init_left--;
      else begin
        if (pred_valid) begin
          e_idx = pred_adrs ^ mghr;
          m_bit = mtbl[e_idx][1];
          m_idx = e_idx;
          q.push_back({m_bit, m_idx});
        end
        if (upd_valid) begin
          if (upd_taken && mtbl[upd_idx] != 2'd3) mtbl[upd_idx] = mtbl[upd_idx] + 2'd1;
          if (!upd_taken && mtbl[upd_idx] != 2'd0) mtbl[upd_idx] = mtbl[upd_idx] - 2'd1;
          mghr = {mghr[6:0], upd_taken};
          if (upd_taken != upd_pred && mcnt != 16'hFFFF) mcnt++;
        end
      end
    end
    started = 1;
    #1;
  endtask

  task automatic upd(input logic [7:0] i, input logic t, input logic p);
    upd_valid = 1; upd_idx = i; upd_taken = t; upd_pred = p;
    step();
    upd_valid = 0;
  endtask

  task automatic predict_at(input logic [7:0] i);
    pred_valid = 1; pred_adrs = i ^ mghr;
    step();
    pred_valid = 0;
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      pred_valid = 1'($urandom_range(0, 1));
      pred_adrs  = 8'($urandom);
      upd_valid  = 1'($urandom_range(0, 1));
      upd_idx    = 8'($urandom_range(0, 7));
      upd_taken  = 1'($urandom_range(0, 1));
      upd_pred   = 1'($urandom_range(0, 1));
      step();
    end
    pred_valid = 0; upd_valid = 0;
  endtask

  always @(negedge clk) if (started) begin
    logic [8:0] e;
    if (prdbit_vld || q.size() > 0) begin
      if (q.size() == 0) chk("vld_spurious", prdbit_vld, 0);
      else begin
        e = q.pop_front();
        chk("vld", prdbit_vld, 1);
        chk("prdbit", prdbit, e[8]);
        chk("pred_idx", pred_idx, e[7:0]);
      end
    end
    chk("hold_bit", prdbit, m_bit);
    chk("hold_idx", pred_idx, m_idx);
    chk("ghr", ghr, mghr);
    chk("mispred_cnt", mispred_cnt, mcnt);
    chk("pred_rdy", pred_rdy, init_left == 0);
    chk("mispred_cnt2", mispred_cnt2, mcnt2);
  end

  initial begin
    rst = 1; step(); rst = 0;
    repeat (255) step();
    chk("init_rdy_lo", pred_rdy, 0);
    step();
    chk("init_rdy_hi", pred_rdy, 1);
    pred_valid = 1; pred_adrs = 8'hA7; step(); pred_valid = 0;
    chk("t1_vld", prdbit_vld, 1);
    chk("t1_bit", prdbit, 0);
    chk("t1_idx", pred_idx, 8'hA7);
    upd(8'h05, 1, 0); upd(8'h05, 1, 0);
    chk("t2_ghr", ghr, 8'h03);
    chk("t2_cnt", mispred_cnt, 2);
    pred_valid = 1; pred_adrs = 8'h06; step(); pred_valid = 0;
    chk("t2_idx", pred_idx, 8'h05);
    chk("t2_bit", prdbit, 1);
    repeat (5) upd(8'h40, 1, 1);
    upd(8'h40, 0, 1);
    predict_at(8'h40);
    chk("t3_bit_after1nt", prdbit, 1);
    repeat (4) upd(8'h40, 0, 0);
    predict_at(8'h40);
    chk("t3_bit_after5nt", prdbit, 0);
    pred_valid = 1; pred_adrs = 8'h20 ^ mghr;
    upd_valid = 1; upd_idx = 8'h20; upd_taken = 1; upd_pred = 0;
    step();
    pred_valid = 0; upd_valid = 0;
    chk("t4_collide_bit", prdbit, 0);
    predict_at(8'h20);
    chk("t4_next_bit", prdbit, 1);
    rand_cycles(400);
    rst = 1; step(); rst = 0;
    rand_cycles(100);
    chk("t6_mid_init_rdy", pred_rdy, 0);
    rst = 1; step(); rst = 0;
    rand_cycles(255);
    chk("t6_rdy_lo", pred_rdy, 0);
    chk("t6_ghr", ghr, 0);
    chk("t6_cnt", mispred_cnt, 0);
    step();
    chk("t6_rdy_hi", pred_rdy, 1);
    for (int k = 0; k < 8; k++) begin
      predict_at(8'h05 + 8'(k * 37));
      chk("t6_pred_zero", prdbit, 0);
    end
    for (int k = 0; k < 20; k++) begin
      upd_valid2 = 1; step();
      chk("t5_sat", mispred_cnt2, k < 15 ? k + 1 : 15);
    end
    upd_valid2 = 0;
    step();
    chk("q_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
